pc_gen: RTL and testbench
=========================

// Module: pc_gen
// PURPOSE
//  Fetch-stage PC register plus next-PC generation for the pipelined CPU.
//  Adds stall hold, exception entry, eret return and a one-entry
//  pending-redirect latch. The latch keeps a decode-stage redirect that
//  arrives while fetch is stalled, and applies it when the stall drops.
//  Also flags misaligned or out-of-range fetch addresses. Sits between the
//  hazard unit / decode stage and the instruction memory.
// PARAMETERS
//  PC_W      32            PC width; must be >= 30
//  RESET_PC  32'h0000_3000 PC value after reset
//  EXC_VEC   32'h0000_4180 exception entry address
//  IMEM_LO   32'h0000_3000 lowest legal fetch address (inclusive)
//  IMEM_HI   32'h0000_6FFC highest legal fetch address (inclusive)
// PORTS
//  clk        in  1     clock, rising edge
//  reset      in  1     synchronous, active-low reset
//  stall      in  1     hold the fetch PC this cycle
//  mode       in  2     00 NEXT, 01 BRANCH, 10 J, 11 JR (from decode)
//  taken      in  1     branch comparison result; used only when mode=BRANCH
//  id_pc      in  PC_W  PC of the instruction in decode
//  imm26      in  26    instruction immediate field; [15:0] is the branch offset
//  reg_value  in  PC_W  JR target register value
//  exc_req    in  1     exception request; redirect to EXC_VEC
//  eret       in  1     return from exception; redirect to epc
//  epc        in  PC_W  exception return address
//  pc         out PC_W  current fetch PC (registered)
//  pc4        out PC_W  pc + 4
//  pend_valid out 1     pending redirect held (registered)
//  fetch_err  out 1     pc misaligned or outside [IMEM_LO, IMEM_HI] (combinational from pc)
// BEHAVIOUR
//  Reset (reset==0 at posedge): pc<=RESET_PC, pend_valid<=0, pend_tgt<=0.
//   fetch_err is therefore 0 if RESET_PC is legal.
//  Redirect request (combinational from decode inputs):
//   BRANCH & taken -> id_pc+4 + {sext(imm26[15:0]),2'b00}
//   J -> {id_pc_plus4[PC_W-1:28], imm26, 2'b00}
//   JR -> reg_value
//   NEXT, or BRANCH & !taken -> no redirect
//  All adds are modulo 2^PC_W; wrap-around is silent.
//  Update priority per posedge (highest first):
//   1 reset
//   2 exc_req: pc<=EXC_VEC, pend_valid<=0; overrides stall and eret
//   3 eret: pc<=epc, pend_valid<=0; overrides stall
//   4 stall & redirect request: pc holds; pend_tgt<=target; pend_valid<=1.
//     A newer request overwrites an older pending one.
//   5 stall, no request: pc holds; pending state holds
//   6 !stall & redirect request: pc<=target; pend_valid<=0.
//     A live request beats a pending one.
//   7 !stall & pend_valid: pc<=pend_tgt; pend_valid<=0
//   8 otherwise: pc<=pc+4
//  Latency: one cycle from redirect/exception input to a visible pc.
//  FSM states: RUN (pend_valid=0) and HOLD (pend_valid=1).
//   RUN->HOLD on rule 4.
//   HOLD->RUN on rules 2, 3, 6 or 7.
//  fetch_err = (pc[1:0]!=0) | (pc<IMEM_LO) | (pc>IMEM_HI). No state change on error.
//  Reset mid-stall or mid-HOLD clears everything on that edge.
// TESTING
//  T1 reset=0 two cycles, then free-run 3 cycles -> pc 3000,3000,3004,3008,300C; fetch_err=0
//  T2 id_pc=3010, mode=BRANCH, taken=1, imm=16'hFFFC -> next pc=3004; taken=0 -> pc+4
//  T3 id_pc=3020, mode=J, imm26=26'h0000C10 -> pc=00003040
//  T4 stall=1 with mode=JR, reg_value=3100 -> pc holds, pend_valid=1;
//     stall drops with mode=NEXT -> pc=3100, pend_valid=0
//  T5 stall=1, exc_req=1, eret=1, pending set -> pc=4180, pend_valid=0;
//     next cycle eret=1, epc=3050 -> pc=3050
//  T6 mode=JR, reg_value=7002 -> pc=7002, fetch_err=1; reset=0 mid-HOLD -> pc=3000, pend_valid=0

Source files
------------

// File: rtl/pc_gen_if.sv
// rtl/pc_gen_if.sv - decode/hazard-side bus and fetch-side outputs of the PC generator
interface pc_gen_if #(
    parameter int PC_W = 32
);
    logic            stall;
    logic [1:0]      mode;
    logic            taken;
    logic [PC_W-1:0] id_pc;
    logic [25:0]     imm26;
    logic [PC_W-1:0] reg_value;
    logic            exc_req;
    logic            eret;
    logic [PC_W-1:0] epc;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc4;
    logic            pend_valid;
    logic            fetch_err;

    // Driver side: hazard unit, decode stage, exception logic
    modport master (
        output stall, mode, taken, id_pc, imm26, reg_value, exc_req, eret, epc,
        input  pc, pc4, pend_valid, fetch_err
    );

    // PC generator side
    modport slave (
        input  stall, mode, taken, id_pc, imm26, reg_value, exc_req, eret, epc,
        output pc, pc4, pend_valid, fetch_err
    );
endinterface

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - fetch PC register with stall hold, exception/eret redirect and pending-redirect latch
module pc_gen #(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = 'h0000_3000,
    parameter logic [PC_W-1:0] EXC_VEC  = 'h0000_4180,
    parameter logic [PC_W-1:0] IMEM_LO  = 'h0000_3000,
    parameter logic [PC_W-1:0] IMEM_HI  = 'h0000_6FFC
) (
    input logic    clk_i,
    input logic    reset_i,
    pc_gen_if.slave bus
);
    localparam logic [1:0] MODE_NEXT   = 2'b00;
    localparam logic [1:0] MODE_BRANCH = 2'b01;
    localparam logic [1:0] MODE_J      = 2'b10;
    localparam logic [1:0] MODE_JR     = 2'b11;

    // HOLD means a redirect seen during a stall is waiting to be applied
    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_e;

    state_e          state_q;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pend_tgt_q;

    logic            redir_req;
    logic [PC_W-1:0] redir_tgt;
    logic [PC_W-1:0] id_pc4;
    logic [PC_W-1:0] br_off;

    assign id_pc4 = bus.id_pc + PC_W'(4);
    assign br_off = {{(PC_W-18){bus.imm26[15]}}, bus.imm26[15:0], 2'b00};

    // Decode-stage redirect request and its target; all adds wrap silently
    always_comb begin
        redir_req = 1'b0;
        redir_tgt = '0;
        case (bus.mode)
            MODE_BRANCH: begin
                if (bus.taken) begin
                    redir_req = 1'b1;
                    redir_tgt = id_pc4 + br_off;
                end
            end
            MODE_J: begin
                redir_req = 1'b1;
                redir_tgt = {id_pc4[PC_W-1:28], bus.imm26, 2'b00};
            end
            MODE_JR: begin
                redir_req = 1'b1;
                redir_tgt = bus.reg_value;
            end
            MODE_NEXT: begin
                redir_req = 1'b0;
            end
            default: begin
                redir_req = 1'b0;
            end
        endcase
    end

    // PC update and RUN/HOLD state, in strict priority order
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            pc_q       <= RESET_PC;
            state_q    <= RUN;
            pend_tgt_q <= '0;
        end else if (bus.exc_req) begin
            pc_q    <= EXC_VEC;
            state_q <= RUN;
        end else if (bus.eret) begin
            pc_q    <= bus.epc;
            state_q <= RUN;
        end else if (bus.stall) begin
            if (redir_req) begin
                pend_tgt_q <= redir_tgt;
                state_q    <= HOLD;
            end
        end else if (redir_req) begin
            pc_q    <= redir_tgt;
            state_q <= RUN;
        end else if (state_q == HOLD) begin
            pc_q    <= pend_tgt_q;
            state_q <= RUN;
        end else begin
            pc_q <= pc_q + PC_W'(4);
        end
    end

    assign bus.pc         = pc_q;
    assign bus.pc4        = pc_q + PC_W'(4);
    assign bus.pend_valid = (state_q == HOLD);
    assign bus.fetch_err  = (pc_q[1:0] != 2'b00) | (pc_q < IMEM_LO) | (pc_q > IMEM_HI);
endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - directed self-checking bench for pc_gen
module tb_pc_gen;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    pc_gen_if #(.PC_W(32)) bus ();

    pc_gen dut (
        .clk_i   (clk),
        .reset_i (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic st, input logic [1:0] md, input logic tk,
                         input logic [31:0] idpc, input logic [25:0] imm,
                         input logic [31:0] rv);
        bus.stall     = st;
        bus.mode      = md;
        bus.taken     = tk;
        bus.id_pc     = idpc;
        bus.imm26     = imm;
        bus.reg_value = rv;
    endtask

    task automatic expect_state(input string tag, input logic [31:0] pc,
                                input logic pv, input logic err);
        check({tag, ".pc"}, bus.pc, pc);
        check({tag, ".pend"}, {31'd0, bus.pend_valid}, {31'd0, pv});
        check({tag, ".err"}, {31'd0, bus.fetch_err}, {31'd0, err});
    endtask

    initial begin
        bus.exc_req = 1'b0;
        bus.eret    = 1'b0;
        bus.epc     = '0;
        drive(1'b0, 2'b00, 1'b0, 32'h0, 26'h0, 32'h0);

        // T1 reset and free run
        step(); expect_state("t1_rst0", 32'h3000, 1'b0, 1'b0);
        step(); expect_state("t1_rst1", 32'h3000, 1'b0, 1'b0);
        check("t1_pc4", bus.pc4, 32'h3004);
        rst_n = 1'b1;
        step(); check("t1_run0", bus.pc, 32'h3004);
        step(); check("t1_run1", bus.pc, 32'h3008);
        step(); expect_state("t1_run2", 32'h300C, 1'b0, 1'b0);

        // T2 backward branch taken, then not taken
        drive(1'b0, 2'b01, 1'b1, 32'h3010, 26'h000FFFC, 32'h0);
        step(); check("t2_taken", bus.pc, 32'h3004);
        bus.taken = 1'b0;
        step(); check("t2_not_taken", bus.pc, 32'h3008);

        // T3 jump
        drive(1'b0, 2'b10, 1'b0, 32'h3020, 26'h0000C10, 32'h0);
        step(); check("t3_j", bus.pc, 32'h3040);

        // T4 JR during stall goes pending, applied when stall drops
        drive(1'b1, 2'b11, 1'b0, 32'h0, 26'h0, 32'h3100);
        step(); expect_state("t4_hold", 32'h3040, 1'b1, 1'b0);
        drive(1'b1, 2'b00, 1'b0, 32'h0, 26'h0, 32'h0);
        step(); expect_state("t4_hold2", 32'h3040, 1'b1, 1'b0);
        drive(1'b0, 2'b00, 1'b0, 32'h0, 26'h0, 32'h0);
        step(); expect_state("t4_apply", 32'h3100, 1'b0, 1'b0);

        // newer pending request overwrites older one
        drive(1'b1, 2'b11, 1'b0, 32'h0, 26'h0, 32'h3200);
        step();
        drive(1'b1, 2'b11, 1'b0, 32'h0, 26'h0, 32'h3300);
        step(); expect_state("ovw_hold", 32'h3100, 1'b1, 1'b0);
        drive(1'b0, 2'b00, 1'b0, 32'h0, 26'h0, 32'h0);
        step(); expect_state("ovw_apply", 32'h3300, 1'b0, 1'b0);

        // live request beats pending one, pending is discarded
        drive(1'b1, 2'b11, 1'b0, 32'h0, 26'h0, 32'h3500);
        step(); check("live_hold.pend", {31'd0, bus.pend_valid}, 32'd1);
        drive(1'b0, 2'b11, 1'b0, 32'h0, 26'h0, 32'h3400);
        step(); expect_state("live_win", 32'h3400, 1'b0, 1'b0);
        drive(1'b0, 2'b00, 1'b0, 32'h0, 26'h0, 32'h0);
        step(); check("live_after", bus.pc, 32'h3404);

        // untaken branch during stall is not a request
        drive(1'b1, 2'b01, 1'b0, 32'h3404, 26'h0000010, 32'h0);
        step(); expect_state("nt_stall", 32'h3404, 1'b0, 1'b0);

        // T5 exception overrides stall, eret and pending; then eret overrides stall
        drive(1'b1, 2'b11, 1'b0, 32'h0, 26'h0, 32'h3600);
        step(); check("t5_pend", {31'd0, bus.pend_valid}, 32'd1);
        bus.exc_req = 1'b1;
        bus.eret    = 1'b1;
        bus.epc     = 32'h3050;
        step(); expect_state("t5_exc", 32'h4180, 1'b0, 1'b0);
        bus.exc_req = 1'b0;
        step(); expect_state("t5_eret", 32'h3050, 1'b0, 1'b0);
        bus.eret = 1'b0;
        drive(1'b0, 2'b00, 1'b0, 32'h0, 26'h0, 32'h0);
        step(); check("t5_after", bus.pc, 32'h3054);

        // fetch_err range and alignment boundaries
        drive(1'b0, 2'b11, 1'b0, 32'h0, 26'h0, 32'h6FFC);
        step(); expect_state("b_hi", 32'h6FFC, 1'b0, 1'b0);
        drive(1'b0, 2'b00, 1'b0, 32'h0, 26'h0, 32'h0);
        step(); expect_state("b_hi_plus", 32'h7000, 1'b0, 1'b1);
        drive(1'b0, 2'b11, 1'b0, 32'h0, 26'h0, 32'h2FFC);
        step(); expect_state("b_lo_minus", 32'h2FFC, 1'b0, 1'b1);
        drive(1'b0, 2'b11, 1'b0, 32'h0, 26'h0, 32'h3000);
        step(); expect_state("b_lo", 32'h3000, 1'b0, 1'b0);
        drive(1'b0, 2'b11, 1'b0, 32'h0, 26'h0, 32'hFFFF_FFFC);
        step(); check("wrap_pc4", bus.pc4, 32'h0);

        // T6 misaligned target, then reset in the middle of HOLD
        drive(1'b0, 2'b11, 1'b0, 32'h0, 26'h0, 32'h7002);
        step(); expect_state("t6_mis", 32'h7002, 1'b0, 1'b1);
        drive(1'b1, 2'b11, 1'b0, 32'h0, 26'h0, 32'h3100);
        step(); expect_state("t6_hold", 32'h7002, 1'b1, 1'b1);
        rst_n = 1'b0;
        step(); expect_state("t6_rst", 32'h3000, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
